// File: rtl/dnn_pkg.sv
// Shared types for the inference sequencing blocks: state encoding, index record
// and the layer-select width rule.
package dnn_pkg;

   localparam int DEF_IDX_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      START_L,
      WAIT_L,
      XFER,
      DRAIN,
      FINISH
   } seq_state_t;

   typedef struct packed {
      logic [DEF_IDX_W-1:0] ch;
      logic [DEF_IDX_W-1:0] row;
      logic [DEF_IDX_W-1:0] col;
   } idx_t;

   // A single layer still needs one select bit so the port never collapses.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/index_walker.sv
// Three-level {ch,row,col} wrap counter: col fastest, then row, then ch.
// load latches the extents and zeroes the counters; last flags the final index.
module index_walker #(
   parameter int IDX_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [IDX_W-1:0]   cfg_ch,
   input  logic [IDX_W-1:0]   cfg_dim,
   output logic [3*IDX_W-1:0] index,
   output logic               last
);

   logic [IDX_W-1:0] ch_reg;
   logic [IDX_W-1:0] row_reg;
   logic [IDX_W-1:0] col_reg;
   logic [IDX_W-1:0] ch_max_reg;
   logic [IDX_W-1:0] dim_max_reg;

   assign index = {ch_reg, row_reg, col_reg};
   assign last  = (ch_reg == ch_max_reg) && (row_reg == dim_max_reg) && (col_reg == dim_max_reg);

   // Extents are stored as max index so the wrap test is a plain equality.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch_reg      <= '0;
         row_reg     <= '0;
         col_reg     <= '0;
         ch_max_reg  <= '0;
         dim_max_reg <= '0;
      end else if (load) begin
         ch_reg      <= '0;
         row_reg     <= '0;
         col_reg     <= '0;
         ch_max_reg  <= cfg_ch - IDX_W'(1);
         dim_max_reg <= cfg_dim - IDX_W'(1);
      end else if (step) begin
         if (col_reg == dim_max_reg) begin
            col_reg <= '0;
            if (row_reg == dim_max_reg) begin
               row_reg <= '0;
               ch_reg  <= (ch_reg == ch_max_reg) ? '0 : ch_reg + IDX_W'(1);
            end else begin
               row_reg <= row_reg + IDX_W'(1);
            end
         end else begin
            col_reg <= col_reg + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/layer_sequencer.sv
// Multi-layer inference sequencer: starts each layer in turn, waits for its
// output-valid, then copies its output memory into the next layer's activations.
module layer_sequencer
   import dnn_pkg::*;
#(
   parameter int NUM_LAYERS = 2,
   parameter int IDX_W      = DEF_IDX_W,
   parameter int SEL_W      = sel_width(NUM_LAYERS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic [NUM_LAYERS-1:0]       layer_start,
   input  logic [NUM_LAYERS-1:0]       layer_done,
   input  logic [NUM_LAYERS*IDX_W-1:0] cfg_out_ch,
   input  logic [NUM_LAYERS*IDX_W-1:0] cfg_out_dim,
   output logic [SEL_W-1:0]            rd_sel,
   output logic [3*IDX_W-1:0]          rd_index,
   output logic [NUM_LAYERS-1:0]       wr_act,
   output logic [3*IDX_W-1:0]          wr_index
);

   localparam int SLOTS = 1 << SEL_W;

   seq_state_t       state_reg;
   logic [SEL_W-1:0] layer_reg;
   logic [IDX_W-1:0] ch_tab  [SLOTS];
   logic [IDX_W-1:0] dim_tab [SLOTS];
   logic [SLOTS-1:0] done_vec;

   // Tables are padded to a power of two so any select value indexes safely.
   for (genvar gi = 0; gi < SLOTS; gi++) begin : g_cfg
      if (gi < NUM_LAYERS) begin : g_real
         assign ch_tab[gi]   = cfg_out_ch[gi*IDX_W +: IDX_W];
         assign dim_tab[gi]  = cfg_out_dim[gi*IDX_W +: IDX_W];
         assign done_vec[gi] = layer_done[gi];
      end else begin : g_pad
         assign ch_tab[gi]   = '0;
         assign dim_tab[gi]  = '0;
         assign done_vec[gi] = 1'b0;
      end
   end

   logic [SEL_W-1:0] next_layer;
   logic             layer_hit;
   logic             last_layer;
   logic             empty_out;
   logic             walk_load;
   logic             walk_step;
   logic             walk_last;

   assign next_layer = layer_reg + SEL_W'(1);
   assign layer_hit  = done_vec[layer_reg];
   assign last_layer = (layer_reg == SEL_W'(NUM_LAYERS - 1));
   assign empty_out  = (ch_tab[layer_reg] == '0) || (dim_tab[layer_reg] == '0);
   assign walk_load  = (state_reg == WAIT_L) && layer_hit && !last_layer && !empty_out;
   assign walk_step  = (state_reg == XFER) && !walk_last;
   assign rd_sel     = layer_reg;

   index_walker #(
      .IDX_W (IDX_W)
   ) u_walker (
      .clk     (clk),
      .reset   (reset),
      .load    (walk_load),
      .step    (walk_step),
      .cfg_ch  (ch_tab[layer_reg]),
      .cfg_dim (dim_tab[layer_reg]),
      .index   (rd_index),
      .last    (walk_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         layer_reg   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         layer_start <= '0;
         wr_act      <= '0;
         wr_index    <= '0;
      end else begin
         layer_start <= '0;
         done        <= 1'b0;
         wr_act      <= '0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg   <= START_L;
                  layer_reg   <= '0;
                  busy        <= 1'b1;
                  layer_start <= NUM_LAYERS'(1);
               end
            end
            START_L: state_reg <= WAIT_L;
            WAIT_L: begin
               if (layer_hit) begin
                  if (last_layer) begin
                     done      <= 1'b1;
                     state_reg <= FINISH;
                  end else if (empty_out) begin
                     layer_reg   <= next_layer;
                     layer_start <= NUM_LAYERS'(1) << next_layer;
                     state_reg   <= START_L;
                  end else begin
                     state_reg <= XFER;
                  end
               end
            end
            XFER: begin
               // Memory read latency is one cycle, so the write trails the read.
               wr_act   <= NUM_LAYERS'(1) << next_layer;
               wr_index <= rd_index;
               if (walk_last) state_reg <= DRAIN;
            end
            DRAIN: begin
               layer_reg   <= next_layer;
               layer_start <= NUM_LAYERS'(1) << next_layer;
               state_reg   <= START_L;
            end
            FINISH: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Multi-layer inference sequencer. It pulses each conv layer's compute start in order and waits for that layer's output-valid. Between layers it walks every output index of layer k and drives read/write indices and write strobes, so layer k's output memory is copied into layer k+1's activation memory. It replaces the single-layer scheduler once a second and further layers are instantiated under the top level.

## Interface
Parameters:
- NUM_LAYERS, 2: number of chained layers (≥1).
- IDX_W, 16: width of one index field.
- SEL_W, $clog2(NUM_LAYERS) (min 1): layer-select width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  begin inference; sampled only in IDLE.
- busy  out  1  high from first cycle after accepted start through the done cycle.
- done  out  1  one-cycle pulse when the last layer completes.
- layer_start  out  NUM_LAYERS  one-hot, one-cycle compute pulse to layer k.
- layer_done  in  NUM_LAYERS  output-valid from each layer (level or pulse).
- cfg_out_ch  in  NUM_LAYERS*IDX_W  output channels of layer k (field k).
- cfg_out_dim  in  NUM_LAYERS*IDX_W  output spatial dim (square) of layer k.
- rd_sel  out  SEL_W  layer whose output memory is being read.
- rd_index  out  3*IDX_W  {ch,row,col} read index into layer rd_sel's output memory.
- wr_act  out  NUM_LAYERS  one-hot activation write strobe to layer k+1.
- wr_index  out  3*IDX_W  {ch,row,col} write index; rd_index delayed one cycle.

## Operation
- States: IDLE → START_L → WAIT_L → (XFER → DRAIN →) START_L … → FINISH → IDLE. Register cur_layer k.
- IDLE: start=1 → START_L, k=0, busy=1. start while busy is ignored.
- START_L: layer_start[k]=1 for exactly one cycle → WAIT_L.
- WAIT_L: waits for layer_done[k]=1; layer_done[j≠k] is ignored. When k=NUM_LAYERS-1 → FINISH. Otherwise, ch=0 or dim=0 → START_L with k+1 (no transfer). Otherwise → XFER.
- XFER: cfg_out_ch[k] and cfg_out_dim[k] are latched on WAIT_L exit. Walk col fastest, then row, then ch, one index per cycle starting at (0,0,0), ending at (ch-1,dim-1,dim-1). Total ch·dim·dim cycles; after the last index → DRAIN.
- Write path: wr_act[k+1] and wr_index follow each XFER read by exactly one cycle (memory read latency 1). DRAIN issues the final write, then → START_L with k+1.
- FINISH: done=1 for one cycle, busy=1 → IDLE (busy=0 the next cycle).
- Counter arithmetic: unsigned, IDX_W bits. Counters wrap to 0 at dim-1 / ch-1; a carry advances the next field. No overflow for cfg values ≤ 2^IDX_W-1.
- rd_sel=k throughout WAIT_L/XFER. rd_index holds its last value outside XFER.

## Timing
- Reset values: busy=0, done=0, layer_start=0, wr_act=0, rd_sel=0, rd_index=0, wr_index=0, state IDLE.
- start sampled at edge t → layer_start[0] high in cycle t+1.
- layer_done[k] sampled at edge t → first rd_index (0,0,0) in cycle t+1. First wr_act in cycle t+2.
- Last read in cycle T → last write (DRAIN) in T+1 → layer_start[k+1] in T+2.
- Last layer's layer_done sampled at t → done in t+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation: immediate return to reset values. Partially copied activations are abandoned; a fresh start is required.
- layer_done held high from a previous run does not trigger early completion, because it is only sampled in WAIT_L after that layer's start pulse.

## Structure
- Shared package dnn_pkg: IDX_W default, state enum (IDLE, START_L, WAIT_L, XFER, DRAIN, FINISH), packed index struct {ch,row,col}.
- Sub-module index_walker: 3-level wrap counter with load/step/last outputs. Reused later for the output-readback path.
- Top level drives the write-data mux from rd_sel; this block carries no data.

## Test plan
- NUM_LAYERS=2, ch0=2, dim0=3; start, then layer_done[0] 5 cycles after the pulse → 18 reads in order (0,0,0)…(1,2,2), 18 wr_act[1] one cycle later with matching wr_index, layer_start[1] 2 cycles after the last read, done 1 cycle after layer_done[1].
- cfg_out_ch[0]=0 → no XFER; layer_start[1] follows layer_done[0] by 1 cycle with no wr_act.
- NUM_LAYERS=1 → layer_start[0], then done 1 cycle after layer_done[0]; wr_act stays 0.
- Second start pulse while busy, plus a spurious layer_done[1] during WAIT_L for layer 0 → both ignored; sequence identical to the first scenario.
- reset asserted mid-XFER (index 7) → all outputs 0 asynchronously; a new start restarts at layer 0 with index (0,0,0).
- IDX_W=16, ch=1, dim=256 → 65536 reads; row wrap at col=255 and the final index (0,255,255) are checked.
